multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Main control FSM for a multi-cycle MIPS-style datapath.
// Moore machine: strobes decode from the state register and the opcode latched in DECODE.
module multi_cycle_control (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   output logic [3:0] ALUOp,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic       SignExtend,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      REXEC  = 4'd6,
      RCOMP  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      IEXEC  = 4'd10,
      ICOMP  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_FUNC = 4'b1111;

   state_t     state;
   state_t     next_state;
   logic [5:0] op_q;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= FETCH;
         op_q  <= 6'b000000;
      end else begin
         state <= next_state;
         if (state == DECODE) begin
            op_q <= Opcode;
         end
      end
   end

   assign State = state;

   always_comb begin
      next_state  = FETCH;
      ALUOp       = 4'b0000;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      SignExtend  = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;

      if (Reset) begin
         // Show the fetch decode with every architectural write suppressed.
         MemRead = 1'b1;
         ALUSrcB = 2'b01;
         ALUOp   = ALU_ADD;
      end else begin
         case (state)
            FETCH: begin
               MemRead    = 1'b1;
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               ALUSrcB    = 2'b01;
               ALUOp      = ALU_ADD;
               next_state = DECODE;
            end
            DECODE: begin
               ALUSrcB    = 2'b11;
               ALUOp      = ALU_ADD;
               SignExtend = 1'b1;
               // The only place the live Opcode is consulted; it is latched on this same edge.
               case (Opcode)
                  OP_RTYPE:                      next_state = REXEC;
                  OP_LW, OP_SW:                  next_state = MEMADR;
                  OP_BEQ:                        next_state = BRANCH;
                  OP_J:                          next_state = JUMP;
                  OP_ADDI, OP_ADDIU, OP_ANDI,
                  OP_ORI, OP_SLTI:               next_state = IEXEC;
                  default:                       next_state = FETCH;
               endcase
            end
            MEMADR: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b10;
               ALUOp      = ALU_ADD;
               SignExtend = 1'b1;
               if (op_q == OP_LW) begin
                  next_state = MEMRD;
               end else if (op_q == OP_SW) begin
                  next_state = MEMWR;
               end else begin
                  next_state = FETCH;
               end
            end
            MEMRD: begin
               MemRead    = 1'b1;
               IorD       = 1'b1;
               next_state = MEMWB;
            end
            MEMWB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               next_state = FETCH;
            end
            MEMWR: begin
               MemWrite   = 1'b1;
               IorD       = 1'b1;
               next_state = FETCH;
            end
            REXEC: begin
               ALUSrcA    = 1'b1;
               ALUOp      = ALU_FUNC;
               next_state = RCOMP;
            end
            RCOMP: begin
               RegDst     = 1'b1;
               RegWrite   = 1'b1;
               next_state = FETCH;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALU_SUB;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               next_state  = FETCH;
            end
            JUMP: begin
               PCWrite    = 1'b1;
               PCSource   = 2'b10;
               next_state = FETCH;
            end
            IEXEC: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b10;
               SignExtend = 1'b1;
               case (op_q)
                  OP_ANDI: begin
                     ALUOp      = ALU_AND;
                     SignExtend = 1'b0;
                  end
                  OP_ORI: begin
                     ALUOp      = ALU_OR;
                     SignExtend = 1'b0;
                  end
                  OP_SLTI: ALUOp = ALU_SLT;
                  default: ALUOp = ALU_ADD;
               endcase
               next_state = ICOMP;
            end
            ICOMP: begin
               RegWrite   = 1'b1;
               next_state = FETCH;
            end
            default: begin
               next_state = FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: walks each instruction class and checks
// the state trace and the full control word in every state.
module tb_multi_cycle_control;

   logic       CLK;
   logic       Reset;
   logic [5:0] Opcode;
   logic [3:0] ALUOp;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, RegDst, ALUSrcA, SignExtend;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] State;

   int n_cmp = 0;
   int n_bad = 0;

   multi_cycle_control dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .ALUOp(ALUOp),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .SignExtend(SignExtend), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .State(State)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
   //                RegWrite,RegDst,ALUSrcA,SignExtend, ALUSrcB, PCSource, ALUOp}
   logic [18:0] ctrl;
   assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegWrite, RegDst, ALUSrcA, SignExtend, ALUSrcB, PCSource, ALUOp};

   localparam logic [18:0] E_FETCH  = {11'b10010100000, 2'b01, 2'b00, 4'b0010};
   localparam logic [18:0] E_RST    = {11'b00010000000, 2'b01, 2'b00, 4'b0010};
   localparam logic [18:0] E_DECODE = {11'b00000000001, 2'b11, 2'b00, 4'b0010};
   localparam logic [18:0] E_MEMADR = {11'b00000000011, 2'b10, 2'b00, 4'b0010};
   localparam logic [18:0] E_MEMRD  = {11'b00110000000, 2'b00, 2'b00, 4'b0000};
   localparam logic [18:0] E_MEMWB  = {11'b00000011000, 2'b00, 2'b00, 4'b0000};
   localparam logic [18:0] E_MEMWR  = {11'b00101000000, 2'b00, 2'b00, 4'b0000};
   localparam logic [18:0] E_REXEC  = {11'b00000000010, 2'b00, 2'b00, 4'b1111};
   localparam logic [18:0] E_RCOMP  = {11'b00000001100, 2'b00, 2'b00, 4'b0000};
   localparam logic [18:0] E_BRANCH = {11'b01000000010, 2'b00, 2'b01, 4'b0110};
   localparam logic [18:0] E_JUMP   = {11'b10000000000, 2'b00, 2'b10, 4'b0000};
   localparam logic [18:0] E_IORI   = {11'b00000000010, 2'b10, 2'b00, 4'b0001};
   localparam logic [18:0] E_IANDI  = {11'b00000000010, 2'b10, 2'b00, 4'b0000};
   localparam logic [18:0] E_IADDI  = {11'b00000000011, 2'b10, 2'b00, 4'b0010};
   localparam logic [18:0] E_ISLTI  = {11'b00000000011, 2'b10, 2'b00, 4'b0111};
   localparam logic [18:0] E_ICOMP  = {11'b00000001000, 2'b00, 2'b00, 4'b0000};

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Reset  = 1'b1;
      Opcode = 6'b100011;
      tick();
      tick();
      n_cmp++;
      if (State !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_state: got %0d want 0", State);
      end
      n_cmp++;
      if (ctrl !== E_RST) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want %b", ctrl, E_RST);
      end
      Reset = 1'b0;
      #1;
      n_cmp++;
      if (ctrl !== E_FETCH) begin
         n_bad++;
         $display("FAIL fetch_after_reset: got %b want %b", ctrl, E_FETCH);
      end
   endtask

   // Runs one instruction from FETCH; st/ex hold the expected trace and control words.
   task automatic test_instr(input string name, input logic [5:0] op,
                             input logic [3:0] st[$], input logic [18:0] ex[$]);
      Opcode = op;
      for (int i = 0; i < st.size(); i++) begin
         if (i > 0) tick();
         n_cmp++;
         if (State !== st[i] || ctrl !== ex[i]) begin
            n_bad++;
            $display("FAIL %s step%0d: state %0d ctrl %b, want state %0d ctrl %b",
                     name, i, State, ctrl, st[i], ex[i]);
         end
      end
   endtask

   task automatic test_lw();
      test_instr("lw", 6'b100011, '{0, 1, 2, 3, 4, 0},
                 '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH});
   endtask

   task automatic test_sw();
      test_instr("sw", 6'b101011, '{0, 1, 2, 5, 0},
                 '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH});
   endtask

   task automatic test_rtype();
      test_instr("rtype", 6'b000000, '{0, 1, 6, 7, 0},
                 '{E_FETCH, E_DECODE, E_REXEC, E_RCOMP, E_FETCH});
   endtask

   task automatic test_imm();
      test_instr("ori",  6'b001101, '{0, 1, 10, 11, 0}, '{E_FETCH, E_DECODE, E_IORI,  E_ICOMP, E_FETCH});
      test_instr("andi", 6'b001100, '{0, 1, 10, 11, 0}, '{E_FETCH, E_DECODE, E_IANDI, E_ICOMP, E_FETCH});
      test_instr("addi", 6'b001000, '{0, 1, 10, 11, 0}, '{E_FETCH, E_DECODE, E_IADDI, E_ICOMP, E_FETCH});
      test_instr("addiu",6'b001001, '{0, 1, 10, 11, 0}, '{E_FETCH, E_DECODE, E_IADDI, E_ICOMP, E_FETCH});
      test_instr("slti", 6'b001010, '{0, 1, 10, 11, 0}, '{E_FETCH, E_DECODE, E_ISLTI, E_ICOMP, E_FETCH});
   endtask

   task automatic test_branch_jump();
      test_instr("beq", 6'b000100, '{0, 1, 8, 0}, '{E_FETCH, E_DECODE, E_BRANCH, E_FETCH});
      test_instr("j",   6'b000010, '{0, 1, 9, 0}, '{E_FETCH, E_DECODE, E_JUMP,   E_FETCH});
   endtask

   task automatic test_unsupported();
      test_instr("op3f", 6'b111111, '{0, 1, 0}, '{E_FETCH, E_DECODE, E_FETCH});
      test_instr("op01", 6'b000001, '{0, 1, 0}, '{E_FETCH, E_DECODE, E_FETCH});
   endtask

   task automatic test_opcode_change();
      Opcode = 6'b101011;
      tick();
      tick();
      n_cmp++;
      if (State !== 4'd2) begin
         n_bad++;
         $display("FAIL chg_memadr: got %0d want 2", State);
      end
      Opcode = 6'b100011;
      #1;
      n_cmp++;
      if (ctrl !== E_MEMADR) begin
         n_bad++;
         $display("FAIL chg_ctrl: got %b want %b", ctrl, E_MEMADR);
      end
      tick();
      n_cmp++;
      if (State !== 4'd5 || ctrl !== E_MEMWR) begin
         n_bad++;
         $display("FAIL chg_next: state %0d ctrl %b, want state 5 ctrl %b", State, ctrl, E_MEMWR);
      end
      // An IEXEC opcode during MEMWR must not divert the return to FETCH.
      Opcode = 6'b001101;
      tick();
      n_cmp++;
      if (State !== 4'd0) begin
         n_bad++;
         $display("FAIL chg_return: got %0d want 0", State);
      end
   endtask

   task automatic test_reset_mid();
      logic saw_regwrite;
      saw_regwrite = 1'b0;
      Opcode = 6'b100011;
      tick();
      tick();
      tick();
      n_cmp++;
      if (State !== 4'd3) begin
         n_bad++;
         $display("FAIL mid_memrd: got %0d want 3", State);
      end
      Reset = 1'b1;
      #1;
      if (RegWrite !== 1'b0) saw_regwrite = 1'b1;
      n_cmp++;
      if (ctrl !== E_RST) begin
         n_bad++;
         $display("FAIL mid_rst_ctrl: got %b want %b", ctrl, E_RST);
      end
      tick();
      if (RegWrite !== 1'b0) saw_regwrite = 1'b1;
      n_cmp++;
      if (State !== 4'd0) begin
         n_bad++;
         $display("FAIL mid_rst_state: got %0d want 0", State);
      end
      Reset = 1'b0;
      #1;
      if (RegWrite !== 1'b0) saw_regwrite = 1'b1;
      tick();
      if (RegWrite !== 1'b0) saw_regwrite = 1'b1;
      n_cmp++;
      if (saw_regwrite !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_rst_regwrite: got %b want 0", saw_regwrite);
      end
      n_cmp++;
      if (State !== 4'd1) begin
         n_bad++;
         $display("FAIL mid_rst_refetch: got %0d want 1", State);
      end
      // Finish this DECODE as an unsupported opcode to land back in FETCH.
      Opcode = 6'b111111;
      tick();
      n_cmp++;
      if (State !== 4'd0) begin
         n_bad++;
         $display("FAIL mid_rst_return: got %0d want 0", State);
      end
   endtask

   task automatic test_back_to_back();
      test_instr("b2b_j",  6'b000010, '{0, 1, 9, 0}, '{E_FETCH, E_DECODE, E_JUMP, E_FETCH});
      test_instr("b2b_lw", 6'b100011, '{0, 1, 2, 3, 4, 0},
                 '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH});
      test_instr("b2b_sw", 6'b101011, '{0, 1, 2, 5, 0},
                 '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH});
   endtask

   initial begin
      Reset  = 1'b1;
      Opcode = 6'b000000;
      test_reset();
      test_lw();
      test_rtype();
      test_imm();
      test_branch_jump();
      test_unsupported();
      test_sw();
      test_opcode_change();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
